food_spawn_ctrl: RTL and testbench
==================================

# food_spawn_ctrl

Sequencer sitting between the game FSM and the 8-bit coordinate RNG; on a spawn request it strobes the RNG, splits the result into x/y, rejects out-of-grid or snake-occupied cells via the occupancy lookup, and retries until a legal food cell is found. It owns the RNG's enable line exclusively and presents one registered food coordinate to the renderer and collision logic.

## Interface
- GRID_W, 12: playable columns (1..16)
- GRID_H, 8: playable rows (1..16)
- MAX_TRIES, 16: random attempts before giving up or falling back (1..255)
- system_clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- spawn_req  in  1  single-cycle request for a new food cell
- eaten  in  1  single-cycle pulse; current food consumed
- rng_enable  out  1  enable strobe to RNG (RNG updates on its rising edge)
- rng_number  in  8  RNG output; [7:4]=x, [3:0]=y
- occ_req  out  1  occupancy query valid
- occ_x, occ_y  out  4 each  queried cell
- occ_ack  in  1  query answered this cycle
- occ_hit  in  1  cell occupied (valid with occ_ack)
- busy  out  1  spawn in progress
- spawn_done  out  1  one-cycle pulse, new food latched
- spawn_fail  out  1  one-cycle pulse, no cell found
- food_x, food_y  out  4 each  current food cell
- food_valid  out  1  food present

## Operation
- States: IDLE, STROBE, SETTLE, CHECK, QUERY, (SCAN), DONE.
- IDLE: spawn_req -> STROBE, tries cleared, busy=1. spawn_req while busy ignored (no queueing).
- STROBE: rng_enable=1 one cycle -> SETTLE.
- SETTLE: rng_enable=0 one cycle; rng_number captured into cand_x/cand_y at end of SETTLE -> CHECK.
- CHECK: tries++ (saturating). If cand_x>=GRID_W or cand_y>=GRID_H: reject. Else -> QUERY.
- QUERY: occ_req=1, occ_x/occ_y=cand, held stable until occ_ack. occ_ack&~occ_hit -> DONE; occ_ack&occ_hit -> reject.
- Reject: tries<MAX_TRIES -> STROBE; else SCAN (macro on) or spawn_fail pulse -> IDLE (macro off).
- DONE: food_x/y<=cand, food_valid<=1, spawn_done=1 one cycle -> IDLE.
- eaten clears food_valid; food_x/y retain value. eaten in same cycle as spawn_done: food_valid=1 (new food wins).
- spawn_fail leaves food_valid/food_x/food_y unchanged.

## Timing
- Reset: state IDLE, rng_enable=0, occ_req=0, occ_x/y=0, busy=0, spawn_done=0, spawn_fail=0, food_x/y=0, food_valid=0, tries=0, cand=0.
- Reset mid-spawn aborts immediately; no done/fail pulse.
- spawn_req at cycle 0: STROBE 1, SETTLE 2, CHECK 3, QUERY from 4; occ_ack at 4 -> spawn_done at 5 (minimum latency 5).
- Each rejected attempt costs 3 cycles (out-of-grid) or 4 + ack wait (occupied).
- busy=1 from cycle after spawn_req through DONE/fail cycle inclusive.
- occ_x/y change only on entry to QUERY or SCAN step; occ_req deasserts the cycle after occ_ack.

## Configuration
- FOOD_SPAWN_SCAN_EN defined: after MAX_TRIES rejects, SCAN walks cells raster order (x fastest) starting at last cand wrapped into grid, querying each; first free cell -> DONE; after GRID_W*GRID_H queries all hit -> spawn_fail.
- Undefined: SCAN state and scanner absent; MAX_TRIES rejects -> spawn_fail.

## Structure
- food_spawn_pkg: state enum, coord_t (4-bit), xy_t struct {x,y}.
- Sub-module grid_scanner (only with macro): start/step inputs, wrapped x/y and wrap-complete flag, parameterised GRID_W/GRID_H.

## Test plan
- RNG model returns 0x35, occupancy empty -> spawn_done at cycle 5, food=(3,5), food_valid=1.
- RNG 0xF2 then 0x21 (GRID_W=12) -> first rejected, food=(2,1), exactly two rng_enable pulses.
- Occupancy hits (4,4), RNG 0x44 then 0x70 -> food=(7,0), two occ queries.
- All RNG values occupied, macro off, MAX_TRIES=4 -> 4 strobes, spawn_fail pulse, food_valid unchanged.
- Macro on, only (0,0) free -> scan reaches (0,0) with wrap, spawn_done, food=(0,0); full grid -> spawn_fail after 96 queries.
- nreset asserted in QUERY -> all outputs reset values next cycle; eaten coincident with spawn_done -> food_valid=1.

Source files
------------

// File: rtl/food_spawn_pkg.sv
// food_spawn_pkg: shared types for the food spawn sequencer.
//   coord_t : 4-bit grid coordinate
//   xy_t    : packed {x, y} cell, same layout as the RNG byte ([7:4]=x, [3:0]=y)
//   state_e : sequencer states; S_SCAN exists only when FOOD_SPAWN_SCAN_EN is defined
package food_spawn_pkg;
  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } xy_t;

`ifdef FOOD_SPAWN_SCAN_EN
  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_SETTLE, S_CHECK, S_QUERY, S_DONE, S_SCAN
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_SETTLE, S_CHECK, S_QUERY, S_DONE
  } state_e;
`endif
endpackage

// File: rtl/food_spawn_ctrl_if.sv
// food_spawn_if: game FSM / RNG / occupancy / renderer signals of the spawn sequencer.
//   slave  : the sequencer side (food_spawn_ctrl)
//   master : the environment side (game FSM, RNG, occupancy table, renderer)
interface food_spawn_if;
  import food_spawn_pkg::*;
  logic       spawn_req;
  logic       eaten;
  logic       rng_enable;
  logic [7:0] rng_number;
  logic       occ_req;
  coord_t     occ_x;
  coord_t     occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic       busy;
  logic       spawn_done;
  logic       spawn_fail;
  coord_t     food_x;
  coord_t     food_y;
  logic       food_valid;

  modport slave (
    input  spawn_req, eaten, rng_number, occ_ack, occ_hit,
    output rng_enable, occ_req, occ_x, occ_y, busy, spawn_done, spawn_fail,
           food_x, food_y, food_valid
  );

  modport master (
    output spawn_req, eaten, rng_number, occ_ack, occ_hit,
    input  rng_enable, occ_req, occ_x, occ_y, busy, spawn_done, spawn_fail,
           food_x, food_y, food_valid
  );
endinterface

// File: rtl/food_spawn_ctrl_grid_scanner.sv
// grid_scanner: raster walker used as the last-resort search once random
// attempts are exhausted. Present only when FOOD_SPAWN_SCAN_EN is defined.
//   start    : load start_xy wrapped into the grid, clear the visit count
//   step     : advance one cell, x fastest, wrapping at the grid edge
//   pos      : current cell
//   last     : current cell is the GRID_W*GRID_H-th cell visited since start
`ifdef FOOD_SPAWN_SCAN_EN
module grid_scanner
  import food_spawn_pkg::*;
#(
  parameter int GRID_W = 12,
  parameter int GRID_H = 8
) (
  input  logic system_clk,
  input  logic nreset,
  input  logic start,
  input  xy_t  start_xy,
  input  logic step,
  output xy_t  pos,
  output logic last
);
  localparam int CELLS = GRID_W * GRID_H;

  xy_t        pos_q, pos_d;
  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    pos_d = pos_q;
    cnt_d = cnt_q;
    if (start) begin
      pos_d.x = coord_t'(32'(start_xy.x) % GRID_W);
      pos_d.y = coord_t'(32'(start_xy.y) % GRID_H);
      cnt_d   = '0;
    end else if (step) begin
      if (pos_q.x == coord_t'(GRID_W - 1)) begin
        pos_d.x = '0;
        pos_d.y = (pos_q.y == coord_t'(GRID_H - 1)) ? '0 : pos_q.y + 4'd1;
      end else begin
        pos_d.x = pos_q.x + 4'd1;
      end
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      pos_q <= '0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

  assign pos  = pos_q;
  assign last = (cnt_q == 9'(CELLS - 1));
endmodule
`endif

// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: on spawn_req, strobes the coordinate RNG, rejects cells that
// are off-grid or occupied, retries up to MAX_TRIES times and latches the
// first legal cell as the current food.
// Optional feature: FOOD_SPAWN_SCAN_EN adds a raster scan after MAX_TRIES rejects.
//   system_clk, nreset (async, active-low)
//   bus (food_spawn_if.slave):
//     spawn_req/eaten in; rng_enable out / rng_number in;
//     occ_req, occ_x, occ_y out / occ_ack, occ_hit in;
//     busy, spawn_done, spawn_fail, food_x, food_y, food_valid out
module food_spawn_ctrl
  import food_spawn_pkg::*;
#(
  parameter int GRID_W    = 12,
  parameter int GRID_H    = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic system_clk,
  input  logic nreset,
  food_spawn_if.slave bus
);
  state_e     state_q, state_d;
  logic [7:0] tries_q, tries_d;
  xy_t        cand_q, cand_d;
  xy_t        occ_q, occ_d;
  xy_t        food_q, food_d;
  logic       occ_req_q, occ_req_d;
  logic       fail_q, fail_d;
  logic       food_valid_q, food_valid_d;
  logic       reject;
  logic       cand_in_grid;

  // 5-bit compare so GRID_W/GRID_H = 16 works
  assign cand_in_grid = ({1'b0, cand_q.x} < 5'(GRID_W)) &&
                        ({1'b0, cand_q.y} < 5'(GRID_H));

`ifdef FOOD_SPAWN_SCAN_EN
  logic scan_start, scan_step, scan_last;
  xy_t  scan_pos;

  grid_scanner #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
    .system_clk (system_clk),
    .nreset     (nreset),
    .start      (scan_start),
    .start_xy   (cand_q),
    .step       (scan_step),
    .pos        (scan_pos),
    .last       (scan_last)
  );
`endif

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cand_d       = cand_q;
    occ_d        = occ_q;
    occ_req_d    = occ_req_q;
    fail_d       = 1'b0;
    food_d       = food_q;
    food_valid_d = food_valid_q & ~bus.eaten;
    reject       = 1'b0;
`ifdef FOOD_SPAWN_SCAN_EN
    scan_start   = 1'b0;
    scan_step    = 1'b0;
`endif
    case (state_q)
      // the fail-pulse cycle still counts as busy, so requests are dropped
      S_IDLE: if (bus.spawn_req && !fail_q) begin
        state_d = S_STROBE;
        tries_d = '0;
      end
      S_STROBE: state_d = S_SETTLE;
      S_SETTLE: begin
        cand_d  = xy_t'(bus.rng_number);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
        if (cand_in_grid) begin
          state_d   = S_QUERY;
          occ_d     = cand_q;
          occ_req_d = 1'b1;
        end else begin
          reject = 1'b1;
        end
      end
      S_QUERY: if (bus.occ_ack) begin
        occ_req_d = 1'b0;
        if (bus.occ_hit) reject = 1'b1;
        else             state_d = S_DONE;
      end
`ifdef FOOD_SPAWN_SCAN_EN
      // each scan query is framed by a low occ_req cycle in which the scanner
      // moves to the next cell
      S_SCAN: begin
        if (!occ_req_q) begin
          occ_req_d = 1'b1;
        end else if (bus.occ_ack) begin
          occ_req_d = 1'b0;
          if (!bus.occ_hit) begin
            cand_d  = scan_pos;
            state_d = S_DONE;
          end else if (scan_last) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            scan_step = 1'b1;
          end
        end
      end
`endif
      // new food overrides a coincident eaten
      S_DONE: begin
        food_d       = cand_q;
        food_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // tries_d already holds this attempt's count
    if (reject) begin
      if (int'(tries_d) < MAX_TRIES) begin
        state_d = S_STROBE;
      end else begin
`ifdef FOOD_SPAWN_SCAN_EN
        state_d    = S_SCAN;
        scan_start = 1'b1;
`else
        state_d = S_IDLE;
        fail_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      tries_q      <= '0;
      cand_q       <= '0;
      occ_q        <= '0;
      occ_req_q    <= 1'b0;
      fail_q       <= 1'b0;
      food_q       <= '0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_q       <= cand_d;
      occ_q        <= occ_d;
      occ_req_q    <= occ_req_d;
      fail_q       <= fail_d;
      food_q       <= food_d;
      food_valid_q <= food_valid_d;
    end
  end

  assign bus.rng_enable = (state_q == S_STROBE);
  assign bus.occ_req    = occ_req_q;
`ifdef FOOD_SPAWN_SCAN_EN
  assign bus.occ_x      = (state_q == S_SCAN) ? scan_pos.x : occ_q.x;
  assign bus.occ_y      = (state_q == S_SCAN) ? scan_pos.y : occ_q.y;
`else
  assign bus.occ_x      = occ_q.x;
  assign bus.occ_y      = occ_q.y;
`endif
  assign bus.busy       = (state_q != S_IDLE) || fail_q;
  assign bus.spawn_done = (state_q == S_DONE);
  assign bus.spawn_fail = fail_q;
  assign bus.food_x     = food_q.x;
  assign bus.food_y     = food_q.y;
  assign bus.food_valid = food_valid_q;
endmodule

// File: tb/tb_food_spawn_ctrl.sv
module tb_food_spawn_ctrl;
  import food_spawn_pkg::*;
  localparam int W = 12, H = 8, MT = 4;

  logic system_clk = 1'b0;
  logic nreset = 1'b0;
  food_spawn_if bus();

  food_spawn_ctrl #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT)) dut (
    .system_clk (system_clk),
    .nreset     (nreset),
    .bus        (bus)
  );

  always #5 system_clk = ~system_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  // ---------------- environment: RNG, occupancy table, monitors ----------------
  logic [7:0] rng_q[$];
  logic [7:0] rng_val = 8'h00;
  bit         occ_map[16][16];
  int         ack_lat = 0, wait_cnt = 0;
  int         strobes = 0, queries = 0, stab_err = 0;
  logic       prev_pend = 1'b0;
  logic [3:0] prev_x = 4'd0, prev_y = 4'd0;

  assign bus.rng_number = rng_val;
  assign bus.occ_ack    = bus.occ_req && (wait_cnt >= ack_lat);
  assign bus.occ_hit    = occ_map[bus.occ_x][bus.occ_y];

  always @(posedge system_clk) begin
    if (bus.rng_enable) begin
      strobes <= strobes + 1;
      if (rng_q.size() > 0) rng_val <= rng_q.pop_front();
    end
    if (bus.occ_req && bus.occ_ack) queries <= queries + 1;
    wait_cnt <= (bus.occ_req && !bus.occ_ack) ? wait_cnt + 1 : 0;
    if (nreset && prev_pend && bus.occ_req && (bus.occ_x !== prev_x || bus.occ_y !== prev_y))
      stab_err <= stab_err + 1;
    prev_pend <= bus.occ_req && !bus.occ_ack;
    prev_x    <= bus.occ_x;
    prev_y    <= bus.occ_y;
  end

  function automatic logic [21:0] outs();
    return {bus.rng_enable, bus.occ_req, bus.occ_x, bus.occ_y, bus.busy, bus.spawn_done,
            bus.spawn_fail, bus.food_x, bus.food_y, bus.food_valid};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] pulse;       // {done, fail}
    int         lat, strobes, queries, busy_low;
    logic [3:0] fx, fy;
    logic       fv, busy_after;
  } res_t;

  logic [3:0] mf_x = 4'd0, mf_y = 4'd0;
  logic       mf_v = 1'b0;

  // Walks the attempt list with the cycle costs of each outcome and returns the
  // expected pulse, its cycle (spawn_req cycle = 0) and the resulting food state.
  function automatic res_t predict(input logic [7:0] seq[$], input int al);
    res_t r;
    int t, cx, cy, sx, sy;
    logic [7:0] b;
    bit found;
    r.pulse = 2'b01; r.lat = 0; r.strobes = 0; r.queries = 0; r.busy_low = 0;
    r.busy_after = 1'b0; r.fx = 4'd0; r.fy = 4'd0; r.fv = 1'b0;
    t = 0; cx = 0; cy = 0; sx = 0; sy = 0; found = 1'b0;
    for (int i = 0; i < MT && !found; i++) begin
      b  = (i < seq.size()) ? seq[i] : seq[seq.size()-1];
      cx = int'(b[7:4]);
      cy = int'(b[3:0]);
      r.strobes++;
      if (cx >= W || cy >= H) t += 3;
      else begin
        r.queries++;
        if (!occ_map[cx][cy]) begin found = 1'b1; r.lat = t + 5 + al; end
        else t += 4 + al;
      end
    end
`ifdef FOOD_SPAWN_SCAN_EN
    if (!found) begin
      sx = cx % W;
      sy = cy % H;
      for (int k = 0; k < W*H && !found; k++) begin
        r.queries++;
        r.lat = t + 3 + al + k*(2 + al);
        if (!occ_map[sx][sy]) begin
          found = 1'b1; cx = sx; cy = sy;
        end else begin
          sx++;
          if (sx == W) begin sx = 0; sy = (sy + 1) % H; end
        end
      end
    end
`else
    if (!found) r.lat = t + 1;
`endif
    if (found) begin
      r.pulse = 2'b10;
      mf_x = 4'(cx); mf_y = 4'(cy); mf_v = 1'b1;
    end
    r.fx = mf_x; r.fy = mf_y; r.fv = mf_v;
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic run(input logic [7:0] seq[$], input int al, input bit eat_on_done, output res_t got);
    int s0, q0, cyc, bl;
    rng_q = seq; ack_lat = al; s0 = strobes; q0 = queries;
    bus.spawn_req = 1'b1; tick(); bus.spawn_req = 1'b0;
    cyc = 1; bl = 0;
    while (!(bus.spawn_done || bus.spawn_fail) && cyc < 3000) begin
      if (bus.busy !== 1'b1) bl++;
      tick(); cyc++;
    end
    if (bus.busy !== 1'b1) bl++;
    got.pulse = {bus.spawn_done, bus.spawn_fail};
    got.lat = cyc; got.busy_low = bl;
    if (eat_on_done) bus.eaten = bus.spawn_done;
    tick();
    bus.eaten = 1'b0;
    got.strobes = strobes - s0; got.queries = queries - q0;
    got.fx = bus.food_x; got.fy = bus.food_y; got.fv = bus.food_valid;
    got.busy_after = bus.busy;
    rng_q.delete();
  endtask

  task automatic cmp(input string tag, input res_t e, input res_t g);
    chk({tag, ".pulse"},    32'(g.pulse),    32'(e.pulse));
    chk({tag, ".latency"},  g.lat,           e.lat);
    chk({tag, ".strobes"},  g.strobes,       e.strobes);
    chk({tag, ".queries"},  g.queries,       e.queries);
    chk({tag, ".food_x"},   32'(g.fx),       32'(e.fx));
    chk({tag, ".food_y"},   32'(g.fy),       32'(e.fy));
    chk({tag, ".food_vld"}, 32'(g.fv),       32'(e.fv));
    chk({tag, ".busy_gap"}, g.busy_low,      e.busy_low);
    chk({tag, ".busy_end"}, 32'(g.busy_after), 32'(e.busy_after));
  endtask

  task automatic clear_occ();
    for (int x = 0; x < 16; x++) for (int y = 0; y < 16; y++) occ_map[x][y] = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string      name;
    logic [7:0] rng [4];
    int         occ_n;
    logic [7:0] occ [4];
    int         al;
    logic [1:0] pulse;
    logic [3:0] fx, fy;
    int         lat, strobes, queries;
  } tv_t;

  tv_t tv_q[$];

  function automatic tv_t mk(input string n, input logic [31:0] rng, input int occ_n,
                             input logic [31:0] occ, input int al, input logic [1:0] p,
                             input logic [7:0] f, input int lat, input int s, input int q);
    tv_t v;
    v.name = n; v.occ_n = occ_n; v.al = al; v.pulse = p;
    v.fx = f[7:4]; v.fy = f[3:0]; v.lat = lat; v.strobes = s; v.queries = q;
    for (int i = 0; i < 4; i++) begin
      v.rng[i] = rng[31-8*i -: 8];
      v.occ[i] = occ[31-8*i -: 8];
    end
    return v;
  endfunction

  res_t exp_r, got_r;
  logic [7:0] sq[$];
  int s0, cyc;

  initial begin
    bus.spawn_req = 1'b0;
    bus.eaten     = 1'b0;
    clear_occ();

    // reset state
    repeat (3) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    nreset = 1'b1;
    tick();
    chk("post_reset_idle", 32'(outs()), 32'd0);

    tv_q.push_back(mk("first_free",   32'h35353535, 0, 32'h0,        0, 2'b10, 8'h35,  5, 1, 1));
    tv_q.push_back(mk("ack_wait",     32'h35353535, 0, 32'h0,        2, 2'b10, 8'h35,  7, 1, 1));
    tv_q.push_back(mk("off_grid",     32'hF2212121, 0, 32'h0,        0, 2'b10, 8'h21,  8, 2, 1));
    tv_q.push_back(mk("occupied",     32'h44707070, 1, 32'h44000000, 0, 2'b10, 8'h70,  9, 2, 2));
`ifndef FOOD_SPAWN_SCAN_EN
    tv_q.push_back(mk("fail_offgrid", 32'h0BC0FF18, 0, 32'h0,        0, 2'b01, 8'h70, 13, 4, 0));
    tv_q.push_back(mk("fail_occ",     32'h11223344, 4, 32'h11223344, 0, 2'b01, 8'h70, 17, 4, 4));
`endif
    foreach (tv_q[i]) begin
      clear_occ();
      for (int k = 0; k < tv_q[i].occ_n; k++) occ_map[tv_q[i].occ[k][7:4]][tv_q[i].occ[k][3:0]] = 1'b1;
      sq.delete();
      for (int k = 0; k < 4; k++) sq.push_back(tv_q[i].rng[k]);
      exp_r.pulse = tv_q[i].pulse; exp_r.lat = tv_q[i].lat; exp_r.strobes = tv_q[i].strobes;
      exp_r.queries = tv_q[i].queries; exp_r.fx = tv_q[i].fx; exp_r.fy = tv_q[i].fy;
      exp_r.fv = 1'b1; exp_r.busy_low = 0; exp_r.busy_after = 1'b0;
      run(sq, tv_q[i].al, 1'b0, got_r);
      cmp(tv_q[i].name, exp_r, got_r);
    end
    mf_x = 4'h7; mf_y = 4'h0; mf_v = 1'b1;

    // second request while busy is dropped
    clear_occ();
    rng_q.delete(); rng_q.push_back(8'h35); rng_q.push_back(8'h21);
    ack_lat = 0; s0 = strobes;
    bus.spawn_req = 1'b1; tick(); bus.spawn_req = 1'b0;
    tick();
    bus.spawn_req = 1'b1; tick(); bus.spawn_req = 1'b0;
    cyc = 3;
    while (!bus.spawn_done && cyc < 20) begin tick(); cyc++; end
    chk("busy_req.latency", cyc, 5);
    repeat (10) tick();
    chk("busy_req.strobes", strobes - s0, 1);
    chk("busy_req.food", {bus.food_x, bus.food_y}, 8'h35);
    chk("busy_req.busy", 32'(bus.busy), 32'd0);
    rng_q.delete();
    mf_x = 4'h3; mf_y = 4'h5; mf_v = 1'b1;

    // eaten while idle clears valid only
    bus.eaten = 1'b1; tick(); bus.eaten = 1'b0;
    chk("eaten.valid", 32'(bus.food_valid), 32'd0);
    chk("eaten.keep_xy", {bus.food_x, bus.food_y}, 8'h35);
    mf_v = 1'b0;

    // eaten coincident with spawn_done: new food stays valid
    sq.delete(); sq.push_back(8'h62);
    exp_r = predict(sq, 0);
    run(sq, 0, 1'b1, got_r);
    cmp("eat_at_done", exp_r, got_r);

    // reset during QUERY aborts with no pulse
    sq.delete(); sq.push_back(8'h35);
    rng_q = sq; ack_lat = 50;
    bus.spawn_req = 1'b1; tick(); bus.spawn_req = 1'b0;
    cyc = 1;
    while (!bus.occ_req && cyc < 20) begin tick(); cyc++; end
    chk("rst_q.query_cycle", cyc, 4);
    chk("rst_q.occ_xy", {bus.occ_x, bus.occ_y}, 8'h35);
    nreset = 1'b0;
    #1;
    chk("rst_q.async_outputs", 32'(outs()), 32'd0);
    tick();
    chk("rst_q.next_cycle", 32'(outs()), 32'd0);
    nreset = 1'b1;
    repeat (6) tick();
    chk("rst_q.no_pulse", 32'(outs()), 32'd0);
    rng_q.delete(); ack_lat = 0;
    mf_x = 4'd0; mf_y = 4'd0; mf_v = 1'b0;

`ifdef FOOD_SPAWN_SCAN_EN
    // only (0,0) free: scan starts at (3,7) and wraps to (0,0)
    for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) occ_map[x][y] = 1'b1;
    occ_map[0][0] = 1'b0;
    sq.delete(); for (int k = 0; k < 4; k++) sq.push_back(8'hF7);
    exp_r = predict(sq, 0);
    run(sq, 0, 1'b0, got_r);
    cmp("scan_wrap", exp_r, got_r);
    chk("scan_wrap.food", {got_r.fx, got_r.fy}, 8'h00);
    occ_map[0][0] = 1'b1;
    exp_r = predict(sq, 1);
    run(sq, 1, 1'b0, got_r);
    cmp("scan_full", exp_r, got_r);
    chk("scan_full.queries", got_r.queries, 96);
`endif

    // randomized runs against the model
    for (int it = 0; it < 40; it++) begin
      int dens, al;
      clear_occ();
      dens = $urandom_range(0, 100);
      for (int x = 0; x < W; x++)
        for (int y = 0; y < H; y++)
          occ_map[x][y] = ($urandom_range(0, 99) < dens);
      sq.delete();
      for (int k = 0; k < 4; k++) sq.push_back({4'($urandom_range(0, 13)), 4'($urandom_range(0, 9))});
      al = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        bus.eaten = 1'b1; tick(); bus.eaten = 1'b0;
        mf_v = 1'b0;
      end
      exp_r = predict(sq, al);
      run(sq, al, 1'b0, got_r);
      cmp($sformatf("rand%0d", it), exp_r, got_r);
    end

    chk("occ_xy_stable", stab_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
